mm2_hdmi: RTL and testbench

//  Stand-alone video test-pattern generator for one project slot of the multi-project harness.

---
 rtl/mm2_hdmi.sv | 158 +++++++++++++++
 tb/tb_mm2_hdmi.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm2_hdmi.sv
//-----------------------------------------------------------------------------
// mm2_hdmi - stand-alone VGA-style test-pattern generator
//
// Generates raster timing (negative-polarity hSync/vSync, 640x480@60 by
// default) from a single pixel clock and drives an 8-bit red channel from a
// 16x16 monochrome tile bitmap. The tile is repeated across the screen, with
// each bitmap bit covering a (2^SCALE_LOG2)x(2^SCALE_LOG2) pixel cell.
// Bitmap rows are loaded one at a time from a 16-bit pad bus. Each load is
// qualified by a rising edge on an asynchronous strobe pin.
//
// Ports
//   clock       in   1   pixel clock, sole clock domain
//   reset       in   1   asynchronous assert, active high
//   io_data     in   16  bitmap row word, bit 15 = leftmost pixel of the row
//   io_newData  in   1   load strobe, asynchronous; one row per rising edge
//   io_red      out  8   red intensity (8'hFF lit / 8'h00 dark), registered
//   io_hSync    out  1   horizontal sync, active low, registered
//   io_vSync    out  1   vertical sync, active low, registered
//
// Load interface: io_newData is not a valid/ready handshake. It is a bare
// strobe with no back-pressure. A rising edge is seen on the third clock
// edge after it reaches the pad. io_data must be stable from the pad edge
// through that clock. Holding the strobe high loads a single row.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module mm2_hdmi #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SCALE_LOG2 = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] io_data,
    input  logic        io_newData,
    output logic [7:0]  io_red,
    output logic        io_hSync,
    output logic        io_vSync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            if (vcnt == V_LAST) begin
                vcnt <= '0;
            end else begin
                vcnt <= vcnt + VW'(1);
            end
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Strobe synchroniser and rising-edge detect.
    // strobe_sync[0] and [1] form the metastability chain. [2] is the
    // delayed copy that the edge detector uses.
    // ------------------------------------------------------------------
    logic [2:0] strobe_sync;
    logic       load;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            strobe_sync <= '0;
        end else begin
            strobe_sync <= {strobe_sync[1:0], io_newData};
        end
    end

    assign load = strobe_sync[1] & ~strobe_sync[2];

    // ------------------------------------------------------------------
    // Bitmap store. It is single buffered, so a row rewritten mid-frame
    // shows from the next pixel that reads it.
    // ------------------------------------------------------------------
    logic [15:0] bitmap [16];
    logic [3:0]  row_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_ptr <= '0;
            for (int i = 0; i < 16; i++) begin
                bitmap[i] <= '0;
            end
        end else if (load) begin
            bitmap[row_ptr] <= io_data;
            row_ptr         <= row_ptr + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Pixel lookup and sync decode, all from the same hcnt/vcnt
    // ------------------------------------------------------------------
    logic       active;
    logic [3:0] row_sel;
    logic [3:0] col_sel;
    logic       pix_bit;
    logic [7:0] red_next;
    logic       hsync_next;
    logic       vsync_next;

    always_comb begin
        active     = (hcnt < H_ACT) && (vcnt < V_ACT);
        // Taking 4 bits above the cell scale makes the tile repeat every
        // 16 cells on each axis.
        row_sel    = vcnt[SCALE_LOG2 +: 4];
        col_sel    = hcnt[SCALE_LOG2 +: 4];
        // Bit 15 is the leftmost column, so the bit index is 15 - col = ~col.
        pix_bit    = bitmap[row_sel][~col_sel];
        red_next   = (active && pix_bit) ? 8'hFF : 8'h00;
        hsync_next = !((hcnt >= H_SYNC_FIRST) && (hcnt <= H_SYNC_LAST));
        vsync_next = !((vcnt >= V_SYNC_FIRST) && (vcnt <= V_SYNC_LAST));
    end

    // A single output stage keeps red and both syncs aligned at one clock
    // of latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_red   <= 8'h00;
            io_hSync <= 1'b1;
            io_vSync <= 1'b1;
        end else begin
            io_red   <= red_next;
            io_hSync <= hsync_next;
            io_vSync <= vsync_next;
        end
    end

endmodule

// File: tb/tb_mm2_hdmi.sv
`timescale 1ns/1ps

module tb_mm2_hdmi;

    // Reduced raster keeps the run short. It is still wider and taller
    // than one 128-pixel tile, so horizontal and vertical repeats are visible.
    localparam int HA    = 136;
    localparam int HFP   = 2;
    localparam int HS    = 4;
    localparam int HBP   = 2;
    localparam int HT    = HA + HFP + HS + HBP;   // 144
    localparam int VA    = 132;
    localparam int VFP   = 1;
    localparam int VS    = 2;
    localparam int VBP   = 2;
    localparam int VT    = VA + VFP + VS + VBP;   // 137
    localparam int FRAME = HT * VT;               // 19728

    logic        clock;
    logic        reset;
    logic [15:0] io_data;
    logic        io_newData;
    logic [7:0]  io_red;
    logic        io_hSync;
    logic        io_vSync;

    int          n_checks;
    int          n_fail;
    int          cyc;
    bit          chk_en;
    int          ptr;
    logic [15:0] exp_bm [16];

    typedef struct {
        int         h;
        int         v;
        logic [7:0] red;
    } probe_t;

    probe_t probes [13];

    mm2_hdmi #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SCALE_LOG2(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io_data(io_data),
        .io_newData(io_newData),
        .io_red(io_red),
        .io_hSync(io_hSync),
        .io_vSync(io_vSync)
    );

    // ---------------- clock / reset-relative cycle count ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Number of clock edges since reset release. After edge n the outputs
    // show raster position n-1.
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_red(input int h, input int v);
        if (h < HA && v < VA && exp_bm[(v >> 3) % 16][15 - ((h >> 3) % 16)])
            return 8'hFF;
        return 8'h00;
    endfunction

    // Compares every output against the raster reference for the current position.
    task automatic check_raster();
        int p, h, v;
        logic [9:0] got, exp;
        p   = cyc - 1;
        h   = p % HT;
        v   = (p / HT) % VT;
        exp = {exp_red(h, v),
               !(h >= HA + HFP && h < HA + HFP + HS),
               !(v >= VA + VFP && v < VA + VFP + VS)};
        got = {io_red, io_hSync, io_vSync};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL raster h=%0d v=%0d: got red=%h hs=%b vs=%b, expected red=%h hs=%b vs=%b",
                     h, v, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clock);
        if (chk_en && !reset && cyc > 0) check_raster();
    endtask

    task automatic wait_to(input int h, input int v);
        int target;
        bit hit;
        target = v * HT + h;
        hit    = 1'b0;
        for (int i = 0; i < FRAME + HT && !hit; i++) begin
            tick();
            if (cyc > 0 && ((cyc - 1) % FRAME) == target) hit = 1'b1;
        end
        check($sformatf("reach_pos_%0d_%0d", h, v), 32'(hit), 32'd1);
    endtask

    // Rising edge held for two clocks and then low for two clocks. io_data
    // stays until the next call, well past the load clock.
    task automatic strobe(input logic [15:0] d);
        io_data    = d;
        io_newData = 1'b1;
        tick();
        tick();
        io_newData = 1'b0;
        tick();
        tick();
        exp_bm[ptr] = d;
        ptr         = (ptr + 1) % 16;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) exp_bm[i] = 16'h0000;
        ptr = 0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        clear_model();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int k, c0;

        n_checks   = 0;
        n_fail     = 0;
        chk_en     = 1'b0;
        io_data    = 16'h0000;
        io_newData = 1'b0;
        reset      = 1'b1;
        clear_model();

        // T3 probe table. Row 0 = 8000 lights x%128<8 and y%128<8.
        probes[0]  = '{h:   0, v:   0, red: 8'hFF};
        probes[1]  = '{h:   7, v:   0, red: 8'hFF};
        probes[2]  = '{h:   8, v:   0, red: 8'h00};
        probes[3]  = '{h: 127, v:   0, red: 8'h00};
        probes[4]  = '{h: 128, v:   0, red: 8'hFF};
        probes[5]  = '{h: 136, v:   0, red: 8'h00};
        probes[6]  = '{h: 135, v:   5, red: 8'hFF};
        probes[7]  = '{h:   3, v:   7, red: 8'hFF};
        probes[8]  = '{h:   3, v:   8, red: 8'h00};
        probes[9]  = '{h:   4, v: 127, red: 8'h00};
        probes[10] = '{h:   0, v: 128, red: 8'hFF};
        probes[11] = '{h: 130, v: 131, red: 8'hFF};
        probes[12] = '{h:   5, v: 132, red: 8'h00};

        // Reset state
        #1;
        check("reset_red",   32'(io_red),   32'h00);
        check("reset_hsync", 32'(io_hSync), 32'd1);
        check("reset_vsync", 32'(io_vSync), 32'd1);
        @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;

        // T1: sync timing with an empty bitmap
        k = 0;
        while (io_hSync === 1'b1 && k < 2 * HT) begin tick(); k++; end
        check("t1_first_hsync_cycle", 32'(k), 32'(HA + HFP + 1));
        c0 = cyc;
        k  = 0;
        while (io_hSync === 1'b0 && k < 2 * HT) begin tick(); k++; end
        check("t1_hsync_width", 32'(k), 32'(HS));
        k = 0;
        while (io_hSync === 1'b1 && k < 2 * HT) begin tick(); k++; end
        check("t1_hsync_period", 32'(cyc - c0), 32'(HT));
        k = 0;
        while (io_vSync === 1'b1 && k < FRAME + HT) begin tick(); k++; end
        check("t1_first_vsync_cycle", 32'(cyc), 32'((VA + VFP) * HT + 1));
        k = 0;
        while (io_vSync === 1'b0 && k < FRAME) begin tick(); k++; end
        check("t1_vsync_width", 32'(k), 32'(VS * HT));

        // T3: one row loaded in vertical blanking, checked over frame 2
        strobe(16'h8000);
        foreach (probes[i]) begin
            wait_to(probes[i].h, probes[i].v);
            check($sformatf("t3_probe_%0d", i), 32'(io_red), 32'(probes[i].red));
        end

        // T2: all rows lit, loaded in blanking, checked over frame 3
        for (int i = 0; i < 16; i++) strobe(16'hFFFF);
        wait_to(100, 130);
        check("t6_red_before_reset", 32'(io_red), 32'hFF);

        // T6: asynchronous reset mid-line
        chk_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t6_red_async",   32'(io_red),   32'h00);
        check("t6_hsync_async", 32'(io_hSync), 32'd1);
        check("t6_vsync_async", 32'(io_vSync), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        clear_model();
        chk_en = 1'b1;
        k = 0;
        while (io_hSync === 1'b1 && k < 2 * HT) begin tick(); k++; end
        check("t6_first_hsync_after_release", 32'(k), 32'(HA + HFP + 1));
        wait_to(0, 16);

        // T4: 17 strobes wrap the pointer and overwrite row 0
        do_reset();
        strobe(16'h0001);
        for (int i = 0; i < 15; i++) strobe(16'h0000);
        strobe(16'hAAAA);
        wait_to(0, 1);
        check("t4_row0_col0", 32'(io_red), 32'hFF);
        chk_en = 1'b1;
        wait_to(124, 2);
        check("t4_old_pattern_gone", 32'(io_red), 32'h00);
        wait_to(0, 16);

        // T5: long level loads once, then a one-clock pulse loads once
        do_reset();
        io_data    = 16'h00FF;
        io_newData = 1'b1;
        exp_bm[0]  = 16'h00FF;
        ptr        = 1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (cyc == 144) chk_en = 1'b1;
        end
        io_newData = 1'b0;
        tick(); tick(); tick();
        io_data = 16'hF0F0;        // no strobe: row 0 must stay 00FF
        tick(); tick();
        io_newData = 1'b1;
        tick();
        io_newData = 1'b0;
        exp_bm[1] = 16'hF0F0;
        ptr       = 2;
        wait_to(0, 8);
        check("t5_row1_col0", 32'(io_red), 32'hFF);
        wait_to(32, 9);
        check("t5_row1_col4", 32'(io_red), 32'h00);
        wait_to(0, 16);
        check("t5_row2_empty", 32'(io_red), 32'h00);
        wait_to(0, 24);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
